// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: parallel-to-serial UART transmit stage.
// Frame: start bit, 8 data bits LSB first, optional parity bit, STOP_BITS stop bits.
// Bit timing comes from an internal divide-by-CLK_PER_BIT baud counter.
// Optional parity bit is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int CLK_PER_BIT = 16,
  parameter int STOP_BITS   = 1
) (
  input  logic       tClk,
  input  logic       tRst,
  input  logic [7:0] tdataIn,
  input  logic       tLoad,
  input  logic       tOddParity,
  output logic       tTxD,
  output logic       tReady,
  output logic       tBusy,
  output logic       tDone
);

  localparam int              CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535) begin : g_bad_clk_per_bit
      $error("uart_tx_serializer: CLK_PER_BIT must be in 2..65535");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_last;

`ifdef UART_TX_PARITY_EN
  // Parity bit is resolved at load time so the shifting data can be discarded.
  logic            parity_q, parity_d;
`else
  logic            unused_odd_parity;
  assign unused_odd_parity = tOddParity;
`endif

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  // Next-state, counter and serial-line decode.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q != S_IDLE) begin
      baud_cnt_d = baud_last ? '0 : baud_cnt_q + CW'(1);
    end
    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (tLoad) begin
          state_d    = S_START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          shift_d    = tdataIn;
          baud_cnt_d = '0;
          bit_cnt_d  = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^tdataIn) ^ tOddParity;
`endif
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d   = S_DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
            txd_d     = parity_q;
`else
            state_d   = S_STOP;
            txd_d     = 1'b1;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d   = S_STOP;
          txd_d     = 1'b1;
          bit_cnt_d = 3'd0;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = S_IDLE;
            txd_d     = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge tClk) begin
    if (tRst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tTxD   = txd_q;
  assign tBusy  = busy_q;
  assign tDone  = done_q;
  assign tReady = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: two instances (1 and 2 stop bits) share
// one stimulus stream; a frame-level model predicts every output each cycle.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LA     = (10 + P) * CPB;  // frame cycles, 1 stop bit
  localparam int LB     = (11 + P) * CPB;  // frame cycles, 2 stop bits
  localparam int MAXAGE = 100;

  logic       tClk = 1'b0;
  logic       tRst, tLoad, tOddParity;
  logic [7:0] tdataIn;
  logic       tx_a, rdy_a, busy_a, done_a;
  logic       tx_b, rdy_b, busy_b, done_b;

  always #5 tClk = ~tClk;

  uart_tx_serializer #(.CLK_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .tClk(tClk), .tRst(tRst), .tdataIn(tdataIn), .tLoad(tLoad),
    .tOddParity(tOddParity), .tTxD(tx_a), .tReady(rdy_a),
    .tBusy(busy_a), .tDone(done_a));

  uart_tx_serializer #(.CLK_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .tClk(tClk), .tRst(tRst), .tdataIn(tdataIn), .tLoad(tLoad),
    .tOddParity(tOddParity), .tTxD(tx_b), .tReady(rdy_b),
    .tBusy(busy_b), .tDone(done_b));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Model: each instance holds at most one frame, described by its start
  // cycle and the serial bit pattern; outputs follow from the frame age.
  bit          m_act[2];
  int          m_start[2];
  logic [11:0] m_bits[2];
  int          m_len[2];

  initial begin
    m_len[0] = LA;
    m_len[1] = LB;
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
  end

  function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic odd);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (P == 1) f[9] = (^d) ^ odd;
    return f;
  endfunction

  // Model update on each active edge.
  always @(posedge tClk) begin
    for (int i = 0; i < 2; i++) begin
      int age;
      bit rdy;
      age = cyc - m_start[i];
      rdy = !m_act[i] || (age >= m_len[i]);
      if (tRst) begin
        m_act[i] = 1'b0;
      end else if (tLoad && rdy) begin
        m_act[i]   = 1'b1;
        m_start[i] = cyc + 1;
        m_bits[i]  = frame_bits(tdataIn, tOddParity);
      end
    end
    cyc++;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge tClk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int age;
        logic [3:0] expv, obs;
        age = cyc - m_start[i];
        if (m_act[i] && age < m_len[i])
          expv = {m_bits[i][age / CPB], 1'b1, 1'b0, 1'b0};
        else
          expv = {1'b1, 1'b0, 1'b1, (m_act[i] && age == m_len[i]) ? 1'b1 : 1'b0};
        obs = (i == 0) ? {tx_a, busy_a, rdy_a, done_a} : {tx_b, busy_b, rdy_b, done_b};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL model_dut%0d cyc %0d tx/busy/ready/done got %b want %b", i, cyc, obs, expv);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, expv);
    end
  endtask

  logic [MAXAGE:0] sa_tx, sa_busy, sa_rdy, sa_done, sb_tx, sb_busy, sb_done;

  function automatic int first_one(input logic [MAXAGE:0] v, input int from);
    for (int k = from; k <= MAXAGE; k++) if (v[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_ones(input logic [MAXAGE:0] v, input int lo, input int hi);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) if (v[k] === 1'b1) n++;
    return n;
  endfunction

  task automatic check_bits(input string nm, input logic [MAXAGE:0] v, input int base,
                            input logic [11:0] expv, input int first, input int n);
    for (int k = first; k < n; k++)
      chk($sformatf("%s_bit%0d", nm, k), int'(v[base + k * CPB + CPB / 2]), int'(expv[k]));
  endtask

  // mode 0: single load; 1: second load attempt at cycle 10;
  // 2: reset pulse at cycle 12; 3: hold tLoad with d2 for a back-to-back frame.
  task automatic run_frame(input logic [7:0] d, input logic odd, input int mode,
                           input logic [7:0] d2);
    @(negedge tClk);
    tdataIn    = d;
    tOddParity = odd;
    tLoad      = 1'b1;
    @(posedge tClk);
    for (int age = 0; age <= MAXAGE; age++) begin
      @(negedge tClk);
      sa_tx[age] = tx_a;  sa_busy[age] = busy_a; sa_rdy[age] = rdy_a; sa_done[age] = done_a;
      sb_tx[age] = tx_b;  sb_busy[age] = busy_b; sb_done[age] = done_b;
      if (age == 0) begin
        if (mode == 3) tdataIn = d2;
        else tLoad = 1'b0;
      end
      if (mode == 1 && age == 9)  begin tLoad = 1'b1; tdataIn = 8'hF0; end
      if (mode == 1 && age == 10) tLoad = 1'b0;
      if (mode == 2 && age == 11) tRst = 1'b1;
      if (mode == 2 && age == 12) tRst = 1'b0;
      if (mode == 3 && age == LB + 1) tLoad = 1'b0;
    end
  endtask

  initial begin
    tRst = 1'b1; tLoad = 1'b0; tdataIn = 8'h00; tOddParity = 1'b0;
    repeat (3) @(posedge tClk);
    @(negedge tClk);
    chk_en = 1'b1;
    chk("reset_tx", int'(tx_a), 1);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_ready", int'(rdy_a), 1);
    chk("reset_done", int'(done_b), 0);
    tRst = 1'b0;

    // Basic frame 0x55.
    run_frame(8'h55, 1'b0, 0, 8'h00);
`ifdef UART_TX_PARITY_EN
    check_bits("f55_a", sa_tx, 0, 12'b0100_1010_1010, 0, 11);
    chk("f55_done_age_a", first_one(sa_done, 0), 44);
    chk("f55_busy_cycles_a", count_ones(sa_busy, 0, MAXAGE), 44);
    chk("f55_done_age_b", first_one(sb_done, 0), 48);
`else
    check_bits("f55_a", sa_tx, 0, 12'b0010_1010_1010, 0, 10);
    chk("f55_done_age_a", first_one(sa_done, 0), 40);
    chk("f55_busy_cycles_a", count_ones(sa_busy, 0, MAXAGE), 40);
    chk("f55_done_age_b", first_one(sb_done, 0), 44);
`endif
    chk("f55_done_count_a", count_ones(sa_done, 0, MAXAGE), 1);

    // Parity select 0xA5, even then odd.
    run_frame(8'hA5, 1'b0, 0, 8'h00);
`ifdef UART_TX_PARITY_EN
    chk("a5_even_parity_bit", int'(sa_tx[9 * CPB + CPB / 2]), 0);
    chk("a5_frame_len", first_one(sa_done, 0), 44);
`else
    chk("a5_stop_bit", int'(sa_tx[9 * CPB + CPB / 2]), 1);
    chk("a5_frame_len", first_one(sa_done, 0), 40);
`endif
    run_frame(8'hA5, 1'b1, 0, 8'h00);
    chk("a5_odd_parity_bit", int'(sa_tx[9 * CPB + CPB / 2]), 1);

    // Load during busy is ignored.
    run_frame(8'h0F, 1'b0, 1, 8'h00);
    check_bits("busyload_a", sa_tx, 0, 12'b0000_0001_1110, 1, 9);
    chk("busyload_done_count", count_ones(sa_done, 0, MAXAGE), 1);

    // Reset mid-frame, then a clean frame.
    run_frame(8'h00, 1'b0, 2, 8'h00);
    chk("midrst_tx", int'(sa_tx[12]), 1);
    chk("midrst_busy", int'(sa_busy[12]), 0);
    chk("midrst_ready", int'(sa_rdy[12]), 1);
    chk("midrst_done_a", count_ones(sa_done, 0, MAXAGE), 0);
    chk("midrst_done_b", count_ones(sb_done, 0, MAXAGE), 0);
    run_frame(8'h81, 1'b0, 0, 8'h00);
`ifdef UART_TX_PARITY_EN
    check_bits("f81_a", sa_tx, 0, 12'b0101_0000_0010, 0, 11);
`else
    check_bits("f81_a", sa_tx, 0, 12'b0011_0000_0010, 0, 10);
`endif

    // Back-to-back: the tDone cycle is the accepting cycle, so the second
    // start bit follows the first frame's stop level with no idle bit.
    run_frame(8'h01, 1'b0, 3, 8'h80);
    chk("b2b_done_cycle_high", int'(sa_tx[LA]), 1);
    chk("b2b_second_start", int'(sa_tx[LA + 1]), 0);
    chk("b2b_second_bit0", int'(sa_tx[LA + 1 + CPB + CPB / 2]), 0);
    chk("b2b_second_bit7", int'(sa_tx[LA + 1 + 8 * CPB + CPB / 2]), 1);
    chk("b2b_done_count", count_ones(sa_done, 0, MAXAGE), 2);
`ifdef UART_TX_PARITY_EN
    chk("b2b_second_done", first_one(sa_done, 45), 89);
`else
    chk("b2b_second_done", first_one(sa_done, 41), 81);
`endif

    // Two stop bits on instance B.
    run_frame(8'hFF, 1'b0, 0, 8'h00);
    chk("stop2_high_cycles", count_ones(sb_tx, (9 + P) * CPB, LB - 1), 8);
`ifdef UART_TX_PARITY_EN
    chk("stop2_done_age", first_one(sb_done, 0), 48);
    chk("stop2_busy_cycles", count_ones(sb_busy, 0, MAXAGE), 48);
`else
    chk("stop2_done_age", first_one(sb_done, 0), 44);
    chk("stop2_busy_cycles", count_ones(sb_busy, 0, MAXAGE), 44);
`endif

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      @(negedge tClk);
      tRst       = ($urandom_range(0, 299) == 0);
      tLoad      = ($urandom_range(0, 2) == 0);
      tdataIn    = 8'($urandom);
      tOddParity = 1'($urandom);
    end
    @(negedge tClk);
    tRst  = 1'b0;
    tLoad = 1'b0;
    repeat (60) @(negedge tClk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
